// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - ID-stage RAW hazard, branch flush and halt-drain control
// Define ID_HAZARD_FWD_EN when EX/MEM forwarding exists: only load-use then stalls.
module id_hazard_ctrl #(
  parameter int SB_DEPTH     = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ID_valid,
  input  logic [2:0] ID_RS,
  input  logic       ID_RS_used,
  input  logic [2:0] ID_RT,
  input  logic       ID_RT_used,
  input  logic [2:0] ID_RD,
  input  logic       ID_RegWrt,
  input  logic       ID_MemRead,
  input  logic       ID_Halt,
  input  logic       EX_BranchTaken,
  output logic       valid,
  output logic       IF_stall,
  output logic       IFID_flush,
  output logic       halted,
  output logic       hazard
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic       wr;
    logic       load;
    logic [2:0] rd;
  } sb_entry_t;

  state_t                     state_q, state_d;
  sb_entry_t [SB_DEPTH-1:0]   sb_q, sb_d;
  logic      [CW-1:0]         cnt_q, cnt_d;
  logic                       raw_hit;
  logic                       unused_sb;

  function automatic logic src_hit(input sb_entry_t e, input logic used, input logic [2:0] r);
    return used & e.wr & (e.rd == r);
  endfunction

  // Bubble slots carry wr=0 and therefore can never produce a match.
  always_comb begin
    raw_hit = 1'b0;
`ifdef ID_HAZARD_FWD_EN
    raw_hit = sb_q[0].load &
              (src_hit(sb_q[0], ID_RS_used, ID_RS) | src_hit(sb_q[0], ID_RT_used, ID_RT));
`else
    for (int k = 0; k < SB_DEPTH; k++) begin
      raw_hit = raw_hit | src_hit(sb_q[k], ID_RS_used, ID_RS) | src_hit(sb_q[k], ID_RT_used, ID_RT);
    end
`endif
  end

  assign unused_sb = ^sb_q;

  always_comb begin
    valid      = 1'b0;
    IF_stall   = 1'b0;
    IFID_flush = 1'b0;
    halted     = 1'b0;
    hazard     = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    sb_d[0]    = '0;
    for (int i = 1; i < SB_DEPTH; i++) begin
      sb_d[i] = sb_q[i-1];
    end

    case (state_q)
      RUN: begin
        if (EX_BranchTaken) begin
          IFID_flush = 1'b1;
        end else if (ID_valid && raw_hit) begin
          hazard   = 1'b1;
          IF_stall = 1'b1;
        end else if (ID_valid) begin
          valid = 1'b1;
        end
        if (valid) begin
          sb_d[0] = {ID_RegWrt, ID_MemRead, ID_RD};
          if (ID_Halt) begin
            state_d = DRAIN;
            cnt_d   = CW'(DRAIN_CYCLES - 1);
          end
        end
      end
      DRAIN: begin
        IF_stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = HALTED;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HALTED: begin
        IF_stall = 1'b1;
        halted   = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (!rst) begin
      valid      = 1'b0;
      IF_stall   = 1'b0;
      IFID_flush = 1'b0;
      halted     = 1'b0;
      hazard     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      sb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
